// File: rtl/mini_src_ctrl_seq.sv
// Mini SRC control-step sequencer: T0-T7 step counter plus HALT, opcode decode into per-step controls.
// Optional macro BRANCH_EN enables decoding of the branch opcode (10011).
module mini_src_ctrl_seq #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    input  logic        con_ff,
    input  logic        stop,
    output logic        run,
    output logic        err,
    output logic [2:0]  step,
    output logic        PCout,
    output logic        IncPC,
    output logic        PCin,
    output logic        MARin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Yin,
    output logic        Cout,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_op
);

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       err_q, err_d;

    logic [4:0] opcode;
    logic       is_alu, is_imm, is_ldi, is_ld, is_st, is_halt, is_br;
    logic       mem_step;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign is_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01011);
    assign is_imm    = (opcode >= 5'b01100) && (opcode <= 5'b01110);
    assign is_ldi    = (opcode == 5'b00001);
    assign is_ld     = (opcode == 5'b00000);
    assign is_st     = (opcode == 5'b00010);
    assign is_halt   = (opcode == 5'b11011);
`ifdef BRANCH_EN
    assign is_br     = (opcode == 5'b10011);
`else
    assign is_br     = 1'b0;
`endif

    // Steps that wait on mem_rdy; the wait counter only advances inside these.
    assign mem_step = (state_q == S_T1) ||
                      (state_q == S_T6 && is_ld) ||
                      (state_q == S_T7 && is_st);

    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        err_d   = err_q;
        case (state_q)
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_halt)
                    state_d = S_HALT;
                else if (is_alu || is_imm || is_ldi || is_ld || is_st || is_br)
                    state_d = S_T4;
                else
                    state_d = stop ? S_HALT : S_T0;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_ld || is_st || is_br) ? S_T6 : (stop ? S_HALT : S_T0);
            S_T6:   state_d = (is_ld || is_st) ? S_T7 : (stop ? S_HALT : S_T0);
            S_T7:   state_d = stop ? S_HALT : S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_T0;
        endcase
        // A memory step holds until mem_rdy; a full wait budget without it is fatal.
        if (mem_step && !mem_rdy) begin
            if (wait_q >= WAIT_MAX) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end else begin
                state_d = state_q;
                wait_d  = wait_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S_T0;
            wait_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign run  = (state_q != S_HALT);
    assign err  = err_q;
    assign step = (state_q == S_HALT) ? 3'd0 : state_q[2:0];

    always_comb begin
        {PCout, IncPC, PCin, MARin, Zin, Zlowout, Yin, Cout} = 8'd0;
        {MDRin, MDRout, Read, Write, IRin, CONin}             = 6'd0;
        {Gra, Grb, Grc, Rin, Rout, BAout}                      = 6'd0;
        alu_op = 5'd0;
        if (!clear && state_q != S_HALT) begin
            alu_op = 5'b00011;
            case (state_q)
                S_T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
                S_T1: {Zlowout, PCin, Read, MDRin} = 4'b1111;
                S_T2: {MDRout, IRin} = 2'b11;
                S_T3: begin
                    if (is_alu || is_imm)             {Grb, Rout, Yin} = 3'b111;
                    else if (is_ldi || is_ld || is_st) {Grb, BAout, Yin} = 3'b111;
                    else if (is_br)                    {Gra, Rout, CONin} = 3'b111;
                end
                S_T4: begin
                    if (is_alu) begin
                        {Grc, Rout, Zin} = 3'b111;
                        alu_op = opcode;
                    end else if (is_imm) begin
                        {Cout, Zin} = 2'b11;
                        case (opcode)
                            5'b01101: alu_op = 5'b00101;
                            5'b01110: alu_op = 5'b00110;
                            default:  alu_op = 5'b00011;
                        endcase
                    end else if (is_ldi || is_ld || is_st) begin
                        {Cout, Zin} = 2'b11;
                    end else if (is_br) begin
                        {PCout, Yin} = 2'b11;
                    end
                end
                S_T5: begin
                    if (is_alu || is_imm || is_ldi) {Zlowout, Gra, Rin} = 3'b111;
                    else if (is_ld || is_st)         {Zlowout, MARin} = 2'b11;
                    else if (is_br)                  {Cout, Zin} = 2'b11;
                end
                S_T6: begin
                    if (is_ld)      {Read, MDRin} = 2'b11;
                    else if (is_st) {Gra, Rout, MDRin} = 3'b111;
                    else if (is_br) begin
                        Zlowout = 1'b1;
                        PCin    = con_ff;
                    end
                end
                S_T7: begin
                    if (is_ld)      {MDRout, Gra, Rin} = 3'b111;
                    else if (is_st) Write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
